// File: rtl/dec_arb_pkg.sv
// Shared definitions for the two-requester arbitrated line decoder.
// Holds the FSM state encoding, hold-time limits and the idle line pattern.
package dec_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 16;
  localparam int CNT_W    = 4;

  localparam logic [7:0] LINES_IDLE = 8'hFF;

endpackage

// File: rtl/dec_3x8.sv
// 3-to-8 decoder with active-low enable and active-low one-cold outputs.
module dec_3x8
  import dec_arb_pkg::*;
(
  input  logic [2:0] code,
  input  logic       en_n,
  output logic [7:0] out_n
);

  always_comb begin
    out_n = LINES_IDLE;
    if (!en_n) out_n[code] = 1'b0;
  end

endmodule

// File: rtl/mux_2x1.sv
// Two-input multiplexer, used to pick the granted requester's address.
module mux_2x1 #(
  parameter int W = 3
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/dec_arb_ctrl.sv
// Round-robin arbiter between two requesters that drives one decoder line
// for HOLD_CYCLES cycles per grant, then pulses the owner's ack.
module dec_arb_ctrl
  import dec_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] addr_a,
  input  logic       req_b,
  input  logic [2:0] addr_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       sel,
  output logic       busy,
  output logic [7:0] line_n,
  output logic [7:0] line
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       addr_q;
  logic [2:0]       addr_win;
  logic [CNT_W-1:0] cnt;
  logic             last_b;
  logic             win_b;
  logic             any_req;

  // On a tie the requester that was not served last wins.
  assign any_req = req_a | req_b;
  assign win_b   = (req_a & req_b) ? ~last_b : req_b;

  mux_2x1 #(.W(3)) u_addr_mux (
    .in0 (addr_a),
    .in1 (addr_b),
    .sel (win_b),
    .y   (addr_win)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (cnt == '0) state_nxt = ST_ACK;
      ST_ACK:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      sel    <= 1'b0;
      addr_q <= 3'd0;
      cnt    <= '0;
      last_b <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            sel    <= win_b;
            addr_q <= addr_win;
            cnt    <= CNT_LOAD;
          end
        end
        ST_ACTIVE: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_ACK:    last_b <= sel;
        default:   ;
      endcase
    end
  end

  // Acks are decoded from state so reset clears them without a register.
  assign ack_a = (state == ST_ACK) & ~sel;
  assign ack_b = (state == ST_ACK) &  sel;
  assign busy  = (state != ST_IDLE);

  dec_3x8 u_dec (
    .code  (addr_q),
    .en_n  (state != ST_ACTIVE),
    .out_n (line_n)
  );

  assign line = ~line_n;

endmodule
